// File: rtl/dpb_port_arbiter_pkg.sv
// Shared types for the two-requester block-RAM port arbiter: FSM states, grant
// encodings and the request payload captured at grant time.
package dpb_port_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    // RAM window decode: an address hits when its masked bits equal the base.
    function automatic logic window_hit(input logic [DATA_W-1:0] addr,
                                        input logic [DATA_W-1:0] base,
                                        input logic [DATA_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/dpb_port_arbiter_arb2_rr.sv
// Combinational two-way grant: round-robin on a tie, or m0 always wins a tie
// when FIXED_PRIO is set.
module arb2_rr
    import dpb_port_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic   req0,
    input  logic   req1,
    input  grant_t last_grant,
    output logic   gnt_valid_c,
    output grant_t grant_c
);

    always_comb begin
        gnt_valid_c = req0 | req1;
        grant_c     = GNT_M0;
        if (req0 && req1) begin
            grant_c = (FIXED_PRIO || (last_grant == GNT_M1)) ? GNT_M0 : GNT_M1;
        end else if (req1) begin
            grant_c = GNT_M1;
        end
    end

endmodule

// File: rtl/dpb_port_arbiter.sv
// Shares one block-RAM port between two native valid/ready requesters (m0, m1).
// Every access runs IDLE -> [ISSUE -> [WAIT]] -> RESP with all outputs registered.
module dpb_port_arbiter
    import dpb_port_arbiter_pkg::*;
#(
    parameter int unsigned ABITS      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] BASE_MASK  = 32'hFFFF_0000,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             m0_valid,
    output logic             m0_ready,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_wstrb,
    output logic [31:0]      m0_rdata,

    input  logic             m1_valid,
    output logic             m1_ready,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_wstrb,
    output logic [31:0]      m1_rdata,

    output logic [ABITS-1:0] mem_ad,
    output logic [31:0]      mem_di,
    output logic [3:0]       mem_wre,
    output logic             mem_sel,
    input  logic [31:0]      mem_do
);

    state_t state;
    grant_t last_grant;
    grant_t grant_q;
    logic   write_q;

    logic   gnt_valid_c;
    grant_t grant_c;
    req_t   req_c;
    logic   hit_c;

    arb2_rr #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .req0       (m0_valid),
        .req1       (m1_valid),
        .last_grant (last_grant),
        .gnt_valid_c(gnt_valid_c),
        .grant_c    (grant_c)
    );

    // Payload of whichever requester the arbiter would grant this cycle.
    always_comb begin
        req_c = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
        if (grant_c == GNT_M1) begin
            req_c = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
        end
        hit_c = window_hit(req_c.addr, BASE_ADDR, BASE_MASK);
    end

    // Strobes and ready pulse are cleared every cycle unless a state sets them;
    // mem_ad/mem_di only load on a hit grant and otherwise hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= GNT_M1;
            grant_q    <= GNT_M0;
            write_q    <= 1'b0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= 32'h0;
            m1_rdata   <= 32'h0;
            mem_ad     <= '0;
            mem_di     <= 32'h0;
            mem_wre    <= 4'h0;
            mem_sel    <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
            mem_wre  <= 4'h0;
            mem_sel  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (gnt_valid_c) begin
                        grant_q    <= grant_c;
                        last_grant <= grant_c;
                        write_q    <= |req_c.wstrb;
                        if (hit_c) begin
                            state   <= ST_ISSUE;
                            mem_sel <= 1'b1;
                            mem_ad  <= {req_c.addr[ABITS-1:2], 2'b00};
                            mem_di  <= req_c.wdata;
                            mem_wre <= req_c.wstrb;
                        end else begin
                            // Outside the window: complete at once, write dropped.
                            state    <= ST_RESP;
                            m0_ready <= (grant_c == GNT_M0);
                            m1_ready <= (grant_c == GNT_M1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (write_q) begin
                        state    <= ST_RESP;
                        m0_ready <= (grant_q == GNT_M0);
                        m1_ready <= (grant_q == GNT_M1);
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state    <= ST_RESP;
                    m0_ready <= (grant_q == GNT_M0);
                    m1_ready <= (grant_q == GNT_M1);
                    if (grant_q == GNT_M0) begin
                        m0_rdata <= mem_do;
                    end else begin
                        m1_rdata <= mem_do;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpb_port_arbiter.sv
// Self-checking bench for dpb_port_arbiter: table of single accesses plus
// hand-written reset, contention and reset-mid-write sequences.
module tb_dpb_port_arbiter;
    import dpb_port_arbiter_pkg::*;

    localparam int unsigned ABITS     = 16;
    localparam int unsigned RAM_WORDS = 2048;
    localparam int unsigned NVEC      = 10;

    logic             clk = 1'b0;
    logic             resetn;
    logic             m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0]      m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]       m0_wstrb, m1_wstrb;
    logic [ABITS-1:0] mem_ad;
    logic [31:0]      mem_di, mem_do;
    logic [3:0]       mem_wre;
    logic             mem_sel;

    logic             fp_m0_ready, fp_m1_ready, fp_mem_sel;
    logic [31:0]      fp_m0_rdata, fp_m1_rdata, fp_mem_di;
    logic [31:0]      fp_mem_do = 32'h0;
    logic [ABITS-1:0] fp_mem_ad;
    logic [3:0]       fp_mem_wre;

    always #5 clk = ~clk;

    dpb_port_arbiter #(.ABITS(ABITS), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .mem_ad(mem_ad), .mem_di(mem_di), .mem_wre(mem_wre),
        .mem_sel(mem_sel), .mem_do(mem_do)
    );

    dpb_port_arbiter #(.ABITS(ABITS), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(fp_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(fp_m1_rdata),
        .mem_ad(fp_mem_ad), .mem_di(fp_mem_di), .mem_wre(fp_mem_wre),
        .mem_sel(fp_mem_sel), .mem_do(fp_mem_do)
    );

    // Block RAM model: read-first, byte-enabled, data one clock after select.
    logic [31:0] ram [RAM_WORDS];
    logic        ram_init;
    logic [10:0] ram_idx;
    assign ram_idx = mem_ad[12:2];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= 32'h0;
            ram[4] <= 32'hDEAD_BEEF;
            ram[8] <= 32'h1122_3344;
        end else if (mem_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wre[b]) ram[ram_idx][b*8 +: 8] <= mem_di[b*8 +: 8];
            end
            mem_do <= ram[ram_idx];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        int          start;
        int          lat;
    } exp_t;

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    exp_t             sbq[$];
    vec_t             vecs[NVEC];
    int               checks = 0;
    int               errors = 0;
    int               sel_cnt = 0, wre_cnt = 0, sel_cyc = 0;
    logic [ABITS-1:0] sel_ad;
    logic [3:0]       wre_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_one(input vec_t v);
        int  sb, wb, start;
        bit  hit, got;
        @(posedge clk); #1;
        sb    = sel_cnt;
        wb    = wre_cnt;
        start = cyc;
        hit   = ((v.addr & 32'hFFFF_0000) == 32'h0);
        sbq.push_back(exp_t'{v.m, v.exp_rdata, start, v.exp_lat});
        if (v.m) begin
            m1_valid = 1'b1; m1_addr = v.addr; m1_wdata = v.wdata; m1_wstrb = v.wstrb;
        end else begin
            m0_valid = 1'b1; m0_addr = v.addr; m0_wdata = v.wdata; m0_wstrb = v.wstrb;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = v.m ? m1_ready : m0_ready;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        chk("ready_seen", 64'(got), 64'd1);
        if (!got) sbq.delete();
        chk("sel_count", 64'(sel_cnt - sb), hit ? 64'd1 : 64'd0);
        if (hit) begin
            chk("sel_addr", 64'(sel_ad), 64'({v.addr[15:2], 2'b00}));
            chk("sel_cycle", 64'(sel_cyc - start), 64'd1);
            chk("wre_count", 64'(wre_cnt - wb), (v.wstrb != 4'h0) ? 64'd1 : 64'd0);
            if (v.wstrb != 4'h0) chk("wre_value", 64'(wre_val), 64'(v.wstrb));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, fp0, fp1;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 3};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h0,         2};
        vecs[2] = '{1'b1, 32'h0000_0020, 32'h0,         4'b0000, 32'h1122_AB44, 3};
        vecs[3] = '{1'b0, 32'h0001_0000, 32'h0,         4'b0000, 32'h0,         1};
        vecs[4] = '{1'b0, 32'h0002_0010, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1};
        vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 3};
        vecs[6] = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'b1111, 32'h0,         2};
        vecs[7] = '{1'b0, 32'h0000_003F, 32'h0,         4'b0000, 32'hCAFE_F00D, 3};
        vecs[8] = '{1'b0, 32'h0000_FFFC, 32'h5A00_0000, 4'b1000, 32'h0,         2};
        vecs[9] = '{1'b1, 32'h0000_FFFC, 32'h0,         4'b0000, 32'h5A00_0000, 3};

        // Scoreboard and RAM-side monitor, sampling on the falling edge.
        fork
            begin : monitor
                exp_t it;
                forever begin
                    @(negedge clk);
                    if (mem_sel) begin
                        sel_cnt++;
                        sel_ad  = mem_ad;
                        sel_cyc = cyc;
                    end
                    if (mem_wre != 4'h0) begin
                        wre_cnt++;
                        wre_val = mem_wre;
                    end
                    if (m0_ready || m1_ready) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_ready", 64'({m0_ready, m1_ready}), 64'd0);
                        end else begin
                            it = sbq.pop_front();
                            chk("ready_owner", 64'({m0_ready, m1_ready}), it.m ? 64'd1 : 64'd2);
                            chk("rdata", 64'(it.m ? m1_rdata : m0_rdata), 64'(it.rdata));
                            chk("other_rdata", 64'(it.m ? m0_rdata : m1_rdata), 64'd0);
                            if (it.lat >= 0) chk("latency", 64'(cyc - it.start), 64'(it.lat));
                        end
                    end
                end
            end
        join_none

        // Reset with random inputs: every output of both instances stays 0.
        resetn   = 1'b0;
        ram_init = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m0_valid = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            m1_valid = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            @(negedge clk);
            chk("rst_ctrl", 64'({m0_ready, m1_ready, mem_sel, mem_wre,
                                 fp_m0_ready, fp_m1_ready, fp_mem_sel, fp_mem_wre}), 64'd0);
            chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
            chk("rst_mem", 64'({mem_ad, mem_di}), 64'd0);
            chk("rst_fp_rdata", {fp_m0_rdata, fp_m1_rdata}, 64'd0);
            chk("rst_fp_mem", 64'({fp_mem_ad, fp_mem_di}), 64'd0);
        end
        m0_valid = 1'b0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_wstrb = 4'h0;
        @(negedge clk);
        resetn   = 1'b1;
        ram_init = 1'b0;

        // Continuous contention from reset: m0 first, then strict alternation.
        @(posedge clk); #1;
        sbq.push_back(exp_t'{1'b0, 32'hDEAD_BEEF, cyc, -1});
        sbq.push_back(exp_t'{1'b1, 32'h1122_3344, cyc, -1});
        sbq.push_back(exp_t'{1'b0, 32'hDEAD_BEEF, cyc, -1});
        sbq.push_back(exp_t'{1'b1, 32'h1122_3344, cyc, -1});
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h20; m1_wstrb = 4'h0;
        n = 0; fp0 = 0; fp1 = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) n++;
            if (fp_m0_ready) fp0++;
            if (fp_m1_ready) fp1++;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        chk("contention_done", 64'(n), 64'd4);
        chk("fixed_m0_grants", 64'(fp0), 64'd4);
        chk("fixed_m1_grants", 64'(fp1), 64'd0);

        for (int i = 0; i < NVEC; i++) run_one(vecs[i]);

        // Reset asserted during ISSUE of a write: strobes drop at once, RAM untouched.
        @(posedge clk); #1;
        m1_valid = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
        @(posedge clk); #1;
        chk("issue_sel", 64'(mem_sel), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_async_sel", 64'(mem_sel), 64'd0);
        chk("rst_async_wre", 64'(mem_wre), 64'd0);
        m1_valid = 1'b0; m1_wstrb = 4'h0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("ram_untouched", 64'(ram[16]), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_one(vec_t'{1'b0, 32'h0000_0040, 32'h0, 4'b0000, 32'h0, 3});
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
